// File: rtl/ram_port_arbiter.sv
// Shares one data-RAM port between the CPU execute stage (priority) and a host requester.
// Latency: MEM_* is combinational from the requests; reads return 1 cycle later; host ACK arrives the cycle after its grant.
// Backpressure: the CPU is stalled for one cycle only on a forced host grant; the host waits at most MAX_WAIT cycles.
module ram_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // CPU execute-stage side
  input  logic              i_cpu_req,
  input  logic              i_cpu_wen,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rvalid,
  // host / debug side
  input  logic              i_host_req,
  input  logic              i_host_wen,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_host_rdata,
  // RAM macro side
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wen,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int              CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {
    ARB    = 1'b0,
    H_DONE = 1'b1
  } arb_state_t;

  arb_state_t       r_fsm;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_cpu_rd_q;
  logic             r_host_rd_q;

  logic w_run;
  logic w_host_elig;
  logic w_force;
  logic w_gnt_h;
  logic w_gnt_c;

  // While reset is held nothing may reach the RAM, so every grant is qualified by w_run.
  assign w_run       = ~i_rst;

  // The host is only considered in ARB; in H_DONE it is still holding the request it was just granted.
  assign w_host_elig = w_run & (r_fsm == ARB) & i_host_req;
  assign w_force     = w_host_elig & (r_wait_cnt == CNT_MAX);
  assign w_gnt_h     = w_host_elig & (~i_cpu_req | w_force);
  assign w_gnt_c     = w_run & i_cpu_req & ~w_gnt_h;

  // RAM port mux: granted requester drives the port; when idle, CPU fields pass through with writes blocked.
  always_comb begin
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_wen   = 1'b0;
    if (w_gnt_h) begin
      o_mem_addr  = i_host_addr;
      o_mem_wdata = i_host_wdata;
      o_mem_wen   = i_host_wen;
    end else if (w_gnt_c) begin
      o_mem_wen   = i_cpu_wen;
    end
  end

  // A CPU stall can only come from the host winning while the CPU also asked.
  assign o_cpu_stall  = i_cpu_req & w_gnt_h;

  assign o_cpu_rvalid = r_cpu_rd_q;
  assign o_cpu_rdata  = i_mem_rdata;

  assign o_host_ack   = (r_fsm == H_DONE);
  assign o_host_rdata = r_host_rd_q ? i_mem_rdata : '0;

  // Arbitration state: a host grant is followed by exactly one completion cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm <= ARB;
    end else begin
      case (r_fsm)
        ARB:     if (w_gnt_h) r_fsm <= H_DONE;
        H_DONE:  r_fsm <= ARB;
        default: r_fsm <= ARB;
      endcase
    end
  end

  // Starvation counter: counts host cycles lost to the CPU, saturating at the force threshold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (w_gnt_h) begin
      r_wait_cnt <= '0;
    end else if ((r_fsm == ARB) && !i_host_req) begin
      r_wait_cnt <= '0;
    end else if (w_host_elig && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Read-in-flight flags line up the 1-cycle RAM read data with the right requester.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpu_rd_q  <= 1'b0;
      r_host_rd_q <= 1'b0;
    end else begin
      r_cpu_rd_q  <= w_gnt_c & ~i_cpu_wen;
      r_host_rd_q <= w_gnt_h & ~i_host_wen;
    end
  end

endmodule
